// File: rtl/branch_hazard_ctrl.sv
// Purpose: branch/jump/jr resolution in ID with operand-hazard stalls; optional stats via BRANCH_STATS_EN.
// Latency: control outputs are combinational from state and inputs; a hazard of depth N adds exactly N stall cycles.
// Backpressure: stalls the front end (PCWrite/IFIDWrite low, IDEXBubble high) until the branch operands are forwardable.
module branch_hazard_ctrl (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        BrValid,
    input  logic [1:0]  BranchAndJump,
    input  logic        UsesRs,
    input  logic        UsesRt,
    input  logic [4:0]  RsId,
    input  logic [4:0]  RtId,
    input  logic        ExRegWrite,
    input  logic        ExMemRead,
    input  logic [4:0]  ExDst,
    input  logic        MemMemRead,
    input  logic [4:0]  MemDst,
    output logic [1:0]  PCSrc,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXBubble,
    output logic        Busy,
    output logic [15:0] BrCount,
    output logic [15:0] TakenCount,
    output logic [15:0] StallCount
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;

    logic       ex_match;
    logic       mem_match;
    logic [1:0] hazard_n;
    logic [1:0] br_target;

    // Operand match against EX/MEM producers and the resulting stall depth; r0 never matches.
    always_comb begin
        ex_match  = (UsesRs && (RsId == ExDst)  && (RsId != 5'd0)) ||
                    (UsesRt && (RtId == ExDst)  && (RtId != 5'd0));
        mem_match = (UsesRs && (RsId == MemDst) && (RsId != 5'd0)) ||
                    (UsesRt && (RtId == MemDst) && (RtId != 5'd0));
        if (ExMemRead && ex_match)
            hazard_n = 2'd2;
        else if (ExRegWrite && ex_match)
            hazard_n = 2'd1;
        else if (MemMemRead && mem_match)
            hazard_n = 2'd1;
        else
            hazard_n = 2'd0;
        // Encoding 11 is treated as no redirect.
        br_target = (BranchAndJump == 2'b11) ? 2'b00 : BranchAndJump;
    end

    // State and stall counter register; reset abandons any pending branch.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and Mealy outputs; a resolve drives the decision, a stall freezes IF/ID and bubbles ID/EX.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        PCSrc      = 2'b00;
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        Busy       = (state != IDLE);
        if (!Rst) begin
            state_nxt = IDLE;
            cnt_nxt   = 2'd0;
            Busy      = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (BrValid) begin
                        if (hazard_n == 2'd0) begin
                            PCSrc     = br_target;
                            IFIDFlush = (br_target != 2'b00);
                        end else begin
                            PCWrite    = 1'b0;
                            IFIDWrite  = 1'b0;
                            IDEXBubble = 1'b1;
                            cnt_nxt    = hazard_n - 2'd1;
                            state_nxt  = (hazard_n == 2'd2) ? STALL : RESOLVE;
                        end
                    end
                end
                STALL: begin
                    if (!BrValid) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 2'd0;
                    end else begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEXBubble = 1'b1;
                        cnt_nxt    = cnt - 2'd1;
                        if (cnt == 2'd1)
                            state_nxt = RESOLVE;
                    end
                end
                RESOLVE: begin
                    // Producers have drained by now, so hazard inputs are not consulted.
                    if (BrValid) begin
                        PCSrc     = br_target;
                        IFIDFlush = (br_target != 2'b00);
                    end
                    state_nxt = IDLE;
                    cnt_nxt   = 2'd0;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic resolve_evt;
    logic taken_evt;
    logic stall_evt;

    // A resolve is a valid branch cycle that is not stalled; a taken resolve is exactly one that flushes.
    always_comb begin
        resolve_evt = Rst && BrValid && !IDEXBubble;
        taken_evt   = IFIDFlush;
        stall_evt   = IDEXBubble;
    end

    // Saturating event counters.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            BrCount    <= 16'd0;
            TakenCount <= 16'd0;
            StallCount <= 16'd0;
        end else begin
            if (resolve_evt && (BrCount != 16'hFFFF))
                BrCount <= BrCount + 16'd1;
            if (taken_evt && (TakenCount != 16'hFFFF))
                TakenCount <= TakenCount + 16'd1;
            if (stall_evt && (StallCount != 16'hFFFF))
                StallCount <= StallCount + 16'd1;
        end
    end
`else
    assign BrCount    = 16'd0;
    assign TakenCount = 16'd0;
    assign StallCount = 16'd0;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Purpose: directed self-checking bench for branch_hazard_ctrl.
// Latency: inputs driven at the falling edge, outputs sampled 1 time unit later.
// Backpressure: n/a (bench).
module tb_branch_hazard_ctrl;

    logic        Clk;
    logic        Rst;
    logic        BrValid;
    logic [1:0]  BranchAndJump;
    logic        UsesRs;
    logic        UsesRt;
    logic [4:0]  RsId;
    logic [4:0]  RtId;
    logic        ExRegWrite;
    logic        ExMemRead;
    logic [4:0]  ExDst;
    logic        MemMemRead;
    logic [4:0]  MemDst;
    logic [1:0]  PCSrc;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IFIDFlush;
    logic        IDEXBubble;
    logic        Busy;
    logic [15:0] BrCount;
    logic [15:0] TakenCount;
    logic [15:0] StallCount;

    int checks = 0;
    int errors = 0;

    logic [6:0] ctl;
    assign ctl = {PCSrc, PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, Busy};

    branch_hazard_ctrl dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .BrValid       (BrValid),
        .BranchAndJump (BranchAndJump),
        .UsesRs        (UsesRs),
        .UsesRt        (UsesRt),
        .RsId          (RsId),
        .RtId          (RtId),
        .ExRegWrite    (ExRegWrite),
        .ExMemRead     (ExMemRead),
        .ExDst         (ExDst),
        .MemMemRead    (MemMemRead),
        .MemDst        (MemDst),
        .PCSrc         (PCSrc),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .IFIDFlush     (IFIDFlush),
        .IDEXBubble    (IDEXBubble),
        .Busy          (Busy),
        .BrCount       (BrCount),
        .TakenCount    (TakenCount),
        .StallCount    (StallCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ctl = {PCSrc[1:0], PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, Busy}
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr;
        BrValid       = 1'b0;
        BranchAndJump = 2'b00;
        UsesRs        = 1'b0;
        UsesRt        = 1'b0;
        RsId          = 5'd0;
        RtId          = 5'd0;
        ExRegWrite    = 1'b0;
        ExMemRead     = 1'b0;
        ExDst         = 5'd0;
        MemMemRead    = 1'b0;
        MemDst        = 5'd0;
    endtask

    initial begin
        // Reset held with a branch present: outputs must still be defaults.
        clr();
        Rst = 1'b0;
        BrValid = 1'b1;
        BranchAndJump = 2'b01;
        #1;
        chk("reset_ctl", {9'd0, ctl}, {9'd0, 7'b00_1_1_0_0_0});
        chk("reset_brcount", BrCount, 16'd0);

        @(negedge Clk);
        Rst = 1'b1;
        clr();
        #1;
        chk("idle_default", {9'd0, ctl}, {9'd0, 7'b00_1_1_0_0_0});

        // No-hazard taken branch resolves in the same cycle.
        @(negedge Clk);
        BrValid = 1'b1;
        BranchAndJump = 2'b01;
        UsesRs = 1'b1;
        RsId = 5'd3;
        ExRegWrite = 1'b1;
        ExDst = 5'd4;
        #1;
        chk("nohaz_taken", {9'd0, ctl}, {9'd0, 7'b01_1_1_1_0_0});

        // Encoding 11 behaves as not-taken.
        @(negedge Clk);
        BranchAndJump = 2'b11;
        #1;
        chk("enc11_none", {9'd0, ctl}, {9'd0, 7'b00_1_1_0_0_0});

        // Load-use in EX: two stall cycles then redirect.
        @(negedge Clk);
        clr();
        BrValid = 1'b1;
        BranchAndJump = 2'b01;
        UsesRs = 1'b1;
        RsId = 5'd5;
        ExMemRead = 1'b1;
        ExDst = 5'd5;
        #1;
        chk("lu_stall1", {9'd0, ctl}, {9'd0, 7'b00_0_0_0_1_0});
        @(negedge Clk); #1;
        chk("lu_stall2", {9'd0, ctl}, {9'd0, 7'b00_0_0_0_1_1});
        @(negedge Clk); #1;
        chk("lu_resolve", {9'd0, ctl}, {9'd0, 7'b01_1_1_1_0_1});
        @(negedge Clk);
        BrValid = 1'b0;
        #1;
        chk("lu_back_idle", {9'd0, ctl}, {9'd0, 7'b00_1_1_0_0_0});

        // ALU producer feeding jr: one stall, then register target.
        @(negedge Clk);
        clr();
        BrValid = 1'b1;
        BranchAndJump = 2'b10;
        UsesRs = 1'b1;
        RsId = 5'd31;
        ExRegWrite = 1'b1;
        ExDst = 5'd31;
        #1;
        chk("jr_stall", {9'd0, ctl}, {9'd0, 7'b00_0_0_0_1_0});
        @(negedge Clk); #1;
        chk("jr_resolve", {9'd0, ctl}, {9'd0, 7'b10_1_1_1_0_1});
        // Same inputs again: a fresh evaluation from IDLE.
        @(negedge Clk); #1;
        chk("b2b_new_eval", {9'd0, ctl}, {9'd0, 7'b00_0_0_0_1_0});
        // Branch withdrawn in RESOLVE: no redirect.
        @(negedge Clk);
        BrValid = 1'b0;
        #1;
        chk("drop_in_resolve", {9'd0, ctl}, {9'd0, 7'b00_1_1_0_0_1});
        @(negedge Clk); #1;
        chk("drop_back_idle", {9'd0, ctl}, {9'd0, 7'b00_1_1_0_0_0});

        // Register 0 never matches.
        clr();
        BrValid = 1'b1;
        BranchAndJump = 2'b00;
        UsesRs = 1'b1;
        ExMemRead = 1'b1;
        #1;
        chk("r0_not_taken", {9'd0, ctl}, {9'd0, 7'b00_1_1_0_0_0});
        @(negedge Clk);
        BranchAndJump = 2'b01;
        #1;
        chk("r0_taken", {9'd0, ctl}, {9'd0, 7'b01_1_1_1_0_0});

        // Load in MEM matching Rt: one stall; with Rt unused no stall.
        @(negedge Clk);
        clr();
        BrValid = 1'b1;
        BranchAndJump = 2'b01;
        UsesRt = 1'b1;
        RtId = 5'd7;
        MemMemRead = 1'b1;
        MemDst = 5'd7;
        #1;
        chk("mem_rt_stall", {9'd0, ctl}, {9'd0, 7'b00_0_0_0_1_0});
        @(negedge Clk); #1;
        chk("mem_rt_resolve", {9'd0, ctl}, {9'd0, 7'b01_1_1_1_0_1});
        @(negedge Clk);
        UsesRt = 1'b0;
        #1;
        chk("rt_unused", {9'd0, ctl}, {9'd0, 7'b01_1_1_1_0_0});

        // EX ALU match outranks nothing deeper: EX write + MEM load both match gives one stall.
        @(negedge Clk);
        clr();
        BrValid = 1'b1;
        BranchAndJump = 2'b01;
        UsesRs = 1'b1;
        RsId = 5'd9;
        ExRegWrite = 1'b1;
        ExDst = 5'd9;
        MemMemRead = 1'b1;
        MemDst = 5'd9;
        #1;
        chk("prio_stall", {9'd0, ctl}, {9'd0, 7'b00_0_0_0_1_0});
        @(negedge Clk); #1;
        chk("prio_resolve", {9'd0, ctl}, {9'd0, 7'b01_1_1_1_0_1});

        // Reset mid-stall abandons the branch.
        @(negedge Clk);
        clr();
        BrValid = 1'b1;
        BranchAndJump = 2'b01;
        UsesRs = 1'b1;
        RsId = 5'd5;
        ExMemRead = 1'b1;
        ExDst = 5'd5;
        @(negedge Clk); #1;
        chk("rst_pre_stall", {9'd0, ctl}, {9'd0, 7'b00_0_0_0_1_1});
        #2;
        Rst = 1'b0;
        #1;
        chk("rst_mid_stall", {9'd0, ctl}, {9'd0, 7'b00_1_1_0_0_0});
        @(negedge Clk);
        Rst = 1'b1;
        BrValid = 1'b0;
        #1;
        chk("rst_release", {9'd0, ctl}, {9'd0, 7'b00_1_1_0_0_0});
        @(negedge Clk); #1;
        chk("rst_no_redirect", {9'd0, ctl}, {9'd0, 7'b00_1_1_0_0_0});

`ifdef BRANCH_STATS_EN
        // Saturation: 65535 taken no-hazard branches, then one more.
        clr();
        Rst = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        chk("stats_cleared", StallCount, 16'd0);
        BrValid = 1'b1;
        BranchAndJump = 2'b01;
        for (int i = 0; i < 65535; i++) @(negedge Clk);
        #1;
        chk("br_at_max", BrCount, 16'hFFFF);
        chk("taken_at_max", TakenCount, 16'hFFFF);
        @(negedge Clk); #1;
        chk("br_saturated", BrCount, 16'hFFFF);
        chk("taken_saturated", TakenCount, 16'hFFFF);
        // One ALU hazard gives exactly one stall cycle.
        clr();
        BrValid = 1'b1;
        BranchAndJump = 2'b01;
        UsesRs = 1'b1;
        RsId = 5'd2;
        ExRegWrite = 1'b1;
        ExDst = 5'd2;
        @(negedge Clk);
        @(negedge Clk);
        BrValid = 1'b0;
        #1;
        chk("stall_count_one", StallCount, 16'd1);
`else
        chk("stats_off_br", BrCount, 16'd0);
        chk("stats_off_taken", TakenCount, 16'd0);
        chk("stats_off_stall", StallCount, 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
